ecg_bit_packer: RTL and testbench

//   Downstream of the BP-mode ECG encoder. Consumes variable-length codewords
//   (encoded_ecg / sizeof_encoded_ecg / valid_op) and packs them MSB-first into

---
 rtl/ecg_bit_packer.sv | 141 ++++++++++++++
 tb/tb_ecg_bit_packer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_bit_packer.sv
// ecg_bit_packer: packs variable-length ECG codewords MSB-first into fixed
// OUT_WIDTH-bit words, with valid/ready on both sides and a flush that
// zero-pads the final partial word and tags it as last.
module ecg_bit_packer #(
  parameter int IN_WIDTH  = 50,
  parameter int LEN_WIDTH = 6,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [LEN_WIDTH-1:0] in_size,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [OUT_WIDTH-1:0] out_word,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 flush_done,
  output logic                 size_err
);

  // Holds one partial word (< OUT_WIDTH bits) plus one maximal codeword.
  localparam int ACC_WIDTH = OUT_WIDTH + IN_WIDTH - 1;
  localparam int CNT_WIDTH = $clog2(ACC_WIDTH + 1);

  localparam logic [LEN_WIDTH-1:0] IN_WIDTH_L  = LEN_WIDTH'(IN_WIDTH);
  localparam logic [CNT_WIDTH-1:0] OUT_WIDTH_C = CNT_WIDTH'(OUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] ACC_WIDTH_C = CNT_WIDTH'(ACC_WIDTH);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   size_err_q, size_err_d;
  logic                   flush_done_q, flush_done_d;

  logic                   accept;
  logic                   emit;
  logic                   size_over;
  logic [LEN_WIDTH-1:0]   size_clamped;
  logic [CNT_WIDTH-1:0]   size_c;
  logic [CNT_WIDTH-1:0]   shift_amt;
  logic [ACC_WIDTH-1:0]   data_masked;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // Register update: FSM state, accumulator, bit count and status flags.
  // NOTE: the accumulator is a plain register bank, not a memory, and it must
  // be reset so that no stale bits can ever be emitted after a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      acc_q        <= '0;
      count_q      <= '0;
      size_err_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      size_err_q   <= size_err_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Datapath next state: append an accepted codeword, or shift out a word.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the block leaves it unassigned and infers a latch.
    acc_d        = acc_q;
    count_d      = count_q;
    size_err_d   = size_err_q;

    size_over    = (in_size > IN_WIDTH_L);
    size_clamped = size_over ? IN_WIDTH_L : in_size;
    size_c       = CNT_WIDTH'(size_clamped);
    data_masked  = ACC_WIDTH'(in_data) & ~({ACC_WIDTH{1'b1}} << size_clamped);
    // count < OUT_WIDTH on accept and size <= IN_WIDTH, so this never underflows.
    shift_amt    = ACC_WIDTH_C - count_q - size_c;

    // Accept needs count < OUT_WIDTH (RUN only), a full-word emit needs
    // count >= OUT_WIDTH and a partial emit needs FLUSH: never both at once.
    if (accept) begin
      acc_d   = acc_q | (data_masked << shift_amt);
      count_d = count_q + size_c;
      if (size_over) begin
        size_err_d = 1'b1;
      end
    end else if (emit) begin
      acc_d   = acc_q << OUT_WIDTH;
      count_d = (count_q >= OUT_WIDTH_C) ? (count_q - OUT_WIDTH_C) : '0;
    end
  end

  // FSM next state: enter FLUSH on request, return to RUN once drained.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_RUN: begin
        // A codeword accepted in the same cycle is already in count_d.
        if (flush) begin
          if (count_d != '0) begin
            state_d = S_FLUSH;
          end else begin
            flush_done_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (emit && (count_d == '0)) begin
          state_d      = S_RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Output decode: registers only, no combinational path from inputs.
  always_comb begin
    in_ready   = (state_q == S_RUN) && (count_q < OUT_WIDTH_C);
    out_valid  = (count_q >= OUT_WIDTH_C) ||
                 ((state_q == S_FLUSH) && (count_q != '0));
    out_last   = (state_q == S_FLUSH) && (count_q != '0) &&
                 (count_q < OUT_WIDTH_C);
    out_word   = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
    flush_done = flush_done_q;
    size_err   = size_err_q;
  end

endmodule

// File: tb/tb_ecg_bit_packer.sv
// Self-checking bench for ecg_bit_packer: a bit-level reference model builds
// expected words into a scoreboard queue as codewords and flushes are driven,
// and each emitted word is popped and compared.
module tb_ecg_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [49:0] in_data;
  logic [5:0]  in_size;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        flush_done;
  logic        size_err;

  ecg_bit_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_size    (in_size),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .flush_done (flush_done),
    .size_err   (size_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        last;
  } exp_t;

  exp_t expq[$];     // scoreboard of words still to be emitted
  bit   mbits[$];    // bits not yet forming a complete word
  int   mcount;      // bits held by the packer
  bit   flushing;
  bit   fd_exp;
  bit   m_size_err;
  int   vectors;
  int   miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_full_words();
    exp_t e;
    while (mbits.size() >= 32) begin
      e.word = '0;
      e.last = 1'b0;
      for (int i = 0; i < 32; i++) e.word[31-i] = mbits.pop_front();
      expq.push_back(e);
    end
  endtask

  task automatic push_partial();
    exp_t e;
    e.word = '0;
    e.last = 1'b1;
    for (int i = 0; i < mbits.size(); i++) e.word[31-i] = mbits[i];
    expq.push_back(e);
    mbits.delete();
  endtask

  task automatic model_reset();
    expq.delete();
    mbits.delete();
    mcount     = 0;
    flushing   = 1'b0;
    fd_exp     = 1'b0;
    m_size_err = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, advance the model for the
  // handshakes of the coming rising edge, then return just after that edge.
  task automatic tick();
    bit   e_valid;
    bit   was_fl;
    bit   acc_now;
    bit   emit_now;
    int   s;
    exp_t e;
    @(negedge clk);
    was_fl  = flushing;
    e_valid = (mcount >= 32) || (flushing && mcount > 0);
    check("in_ready",   64'(in_ready),   64'(!flushing && mcount < 32));
    check("out_valid",  64'(out_valid),  64'(e_valid));
    check("out_last",   64'(out_last),   64'(flushing && mcount > 0 && mcount < 32));
    check("size_err",   64'(size_err),   64'(m_size_err));
    check("flush_done", 64'(flush_done), 64'(fd_exp));
    if (e_valid && expq.size() > 0) begin
      check("out_word", 64'(out_word), 64'(expq[0].word));
    end
    acc_now  = in_valid && !flushing && mcount < 32;
    emit_now = e_valid && out_ready;
    fd_exp   = 1'b0;
    if (emit_now) begin
      if (expq.size() > 0) e = expq.pop_front();
      mcount = (mcount >= 32) ? mcount - 32 : 0;
      if (flushing && mcount == 0) begin
        flushing = 1'b0;
        fd_exp   = 1'b1;
      end
    end
    if (acc_now) begin
      s = (in_size > 50) ? 50 : int'(in_size);
      if (in_size > 50) m_size_err = 1'b1;
      for (int i = s - 1; i >= 0; i--) mbits.push_back(in_data[i]);
      mcount += s;
      push_full_words();
    end
    if (flush && !was_fl) begin
      if (mcount > 0) begin
        flushing = 1'b1;
        if (mbits.size() > 0) push_partial();
      end else begin
        fd_exp = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [49:0] d, input logic [5:0] sz);
    int  n;
    bit  took;
    in_data  = d;
    in_size  = sz;
    in_valid = 1'b1;
    n        = 0;
    took     = 1'b0;
    while (!took && n < 100) begin
      took = in_ready;
      tick();
      n++;
    end
    check("accept_in_time", 64'(took), 64'(1));
    in_valid = 1'b0;
    in_data  = '0;
    in_size  = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || flushing || fd_exp) && n < 100) begin
      tick();
      n++;
    end
    check("drain_in_time", 64'(n < 100), 64'(1));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst       = 1'b0;
    in_data   = '0;
    in_size   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #22;
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_out_word",   64'(out_word),   64'(0));
    check("rst_out_last",   64'(out_last),   64'(0));
    check("rst_flush_done", 64'(flush_done), 64'(0));
    check("rst_size_err",   64'(size_err),   64'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: two codewords form exactly one word
    send(50'hABCDE, 6'd20);
    send(50'h123, 6'd12);
    drain();
    check("t1_empty", 64'(mcount), 64'(0));

    // 2: partial word flushed and marked last
    send(50'h5A, 6'd8);
    do_flush();
    drain();
    tick();

    // 3: count 31 plus a 50-bit codeword -> two words, 17 bits left
    send(50'h0_0000_5555_5555, 6'd31);
    send(50'h3_FFFF_FFFF_FFFF, 6'd50);
    check("t3_count81", 64'(mcount), 64'(81));
    drain();
    check("t3_count17", 64'(mcount), 64'(17));
    tick();
    do_flush();
    drain();

    // 4: back-pressure with a word pending
    out_ready = 1'b0;
    send(50'hBEEF, 6'd16);
    send(50'hCAFE, 6'd16);
    for (int i = 0; i < 10; i++) tick();
    check("t4_pending", 64'(expq.size()), 64'(1));
    out_ready = 1'b1;
    drain();

    // Flush asserted again while already flushing is ignored
    out_ready = 1'b0;
    send(50'hC3, 6'd8);
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b1;
    drain();

    // Flush with nothing buffered: only flush_done
    do_flush();
    drain();

    // 5: zero-length codeword, then an oversize length clamped to 50
    send(50'h3_FFFF_FFFF_FFFF, 6'd0);
    check("t5_size0", 64'(mcount), 64'(0));
    send(50'h2_AAAA_AAAA_AAAA, 6'd63);
    check("t5_clamp", 64'(mcount), 64'(50));
    drain();
    do_flush();
    drain();
    for (int i = 0; i < 3; i++) tick();

    // 6: asynchronous reset with 40 bits buffered
    out_ready = 1'b0;
    send(50'h12345, 6'd20);
    send(50'h6789A, 6'd20);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("t6_out_valid", 64'(out_valid), 64'(0));
    check("t6_out_word",  64'(out_word),  64'(0));
    check("t6_size_err",  64'(size_err),  64'(0));
    model_reset();
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Stream continues correctly after the reset
    send(50'h0F0F, 6'd16);
    send(50'h1F0F0, 6'd17);
    do_flush();
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
